// File: rtl/axil_regcheck_master_if.sv
// ============================================================================
// Module   : axil_regcheck_master_if
// Purpose  : AXI4-Lite channel bundle with master/slave views
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axil_regcheck_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

`default_nettype wire

// File: rtl/axil_regcheck_master.sv
// ============================================================================
// Module   : axil_regcheck_master
// Purpose  : AXI4-Lite write/read-back register sweep with first-failure capture
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_regcheck_master #(
  parameter int                              C_M_AXI_ADDR_WIDTH = 32,
  parameter int                              C_M_AXI_DATA_WIDTH = 32,
  parameter int                              NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = '0,
  parameter int                              TIMEOUT            = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              start,
  input  logic                              mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [$clog2(NUM_REGS+1)-1:0]     err_count,
  output logic                              resp_err,
  output logic                              timeout,
  output logic [7:0]                        fail_index,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     fail_expected,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     fail_actual,
  axil_regcheck_master_if.master            m_axi
);
  localparam int                DW        = C_M_AXI_DATA_WIDTH;
  localparam int                AW        = C_M_AXI_ADDR_WIDTH;
  localparam int                C_ERR_W   = $clog2(NUM_REGS + 1);
  localparam int                C_TO_W    = $clog2(TIMEOUT);
  localparam logic [AW-1:0]     C_STRIDE  = AW'(DW / 8);
  localparam logic [7:0]        C_LAST    = 8'(NUM_REGS - 1);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WR = 3'd1, S_WB = 3'd2, S_RA = 3'd3, S_RD = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t               state_q;
  logic [7:0]           idx_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        data_q;
  logic [C_TO_W-1:0]    cnt_q;
  logic                 reg_fail_q;
  logic                 awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                 busy_q, done_q, pass_q, resp_err_q, timeout_q;
  logic [C_ERR_W-1:0]   err_count_q;
  logic [7:0]           fail_index_q;
  logic [DW-1:0]        fail_expected_q, fail_actual_q;

  logic w_aw_done, w_w_done, w_rd_fail, w_progress, w_abort;

  assign w_aw_done = !awvalid_q || m_axi.AWREADY;
  assign w_w_done  = !wvalid_q  || m_axi.WREADY;
  assign w_rd_fail = reg_fail_q || (m_axi.RDATA != data_q) || (m_axi.RRESP != 2'b00);

  always_comb begin
    w_progress = 1'b0;
    case (state_q)
      S_WR:    w_progress = w_aw_done && w_w_done;
      S_WB:    w_progress = m_axi.BVALID;
      S_RA:    w_progress = m_axi.ARREADY;
      S_RD:    w_progress = m_axi.RVALID;
      default: w_progress = 1'b0;
    endcase
  end

  assign w_abort = (state_q inside {S_WR, S_WB, S_RA, S_RD}) && !w_progress &&
                   (cnt_q == C_TO_LAST);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      cnt_q           <= '0;
      reg_fail_q      <= 1'b0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      resp_err_q      <= 1'b0;
      timeout_q       <= 1'b0;
      err_count_q     <= '0;
      fail_index_q    <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      cnt_q <= cnt_q + C_TO_W'(1);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // Both modes advance by rotating the previous pattern left by one.
            data_q          <= mode ? DW'(1) : seed;
            addr_q          <= BASE_ADDR;
            idx_q           <= '0;
            reg_fail_q      <= 1'b0;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            resp_err_q      <= 1'b0;
            timeout_q       <= 1'b0;
            err_count_q     <= '0;
            fail_index_q    <= '0;
            fail_expected_q <= '0;
            fail_actual_q   <= '0;
            awvalid_q       <= 1'b1;
            wvalid_q        <= 1'b1;
            cnt_q           <= '0;
            state_q         <= S_WR;
          end
        end
        S_WR: begin
          if (m_axi.AWREADY) awvalid_q <= 1'b0;
          if (m_axi.WREADY)  wvalid_q  <= 1'b0;
          if (w_progress) begin
            bready_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_WB;
          end
        end
        S_WB: begin
          if (w_progress) begin
            bready_q <= 1'b0;
            if (m_axi.BRESP != 2'b00) begin
              resp_err_q <= 1'b1;
              reg_fail_q <= 1'b1;
            end
            arvalid_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_RA;
          end
        end
        S_RA: begin
          if (w_progress) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          if (w_progress) begin
            rready_q <= 1'b0;
            if (m_axi.RRESP != 2'b00) resp_err_q <= 1'b1;
            if (w_rd_fail) begin
              err_count_q <= err_count_q + C_ERR_W'(1);
              if (err_count_q == '0) begin
                fail_index_q    <= idx_q;
                fail_expected_q <= data_q;
                fail_actual_q   <= m_axi.RDATA;
              end
            end
            cnt_q <= '0;
            if (idx_q == C_LAST) begin
              pass_q  <= !w_rd_fail && (err_count_q == '0) && !resp_err_q;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q      <= idx_q + 8'd1;
              addr_q     <= addr_q + C_STRIDE;
              data_q     <= {data_q[DW-2:0], data_q[DW-1]};
              reg_fail_q <= 1'b0;
              awvalid_q  <= 1'b1;
              wvalid_q   <= 1'b1;
              state_q    <= S_WR;
            end
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // A stalled handshake abandons the sweep; late slave responses are ignored.
      if (w_abort) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        timeout_q <= 1'b1;
        pass_q    <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        cnt_q     <= '0;
        state_q   <= S_DONE;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign resp_err      = resp_err_q;
  assign timeout       = timeout_q;
  assign fail_index    = fail_index_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;

  assign m_axi.AWADDR  = addr_q;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = data_q;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = bready_q;
  assign m_axi.ARADDR  = addr_q;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = rready_q;
endmodule

`default_nettype wire

// File: tb/tb_axil_regcheck_master.sv
// ============================================================================
// Module   : tb_axil_regcheck_master
// Purpose  : Self-checking bench with a memory slave and a pattern/result model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_regcheck_master;
  localparam int NREG = 4;
  localparam int TOUT = 16;

  logic        ACLK    = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start   = 1'b0;
  logic        mode    = 1'b0;
  logic [31:0] seed    = '0;
  logic        busy, done, pass, resp_err, timeout;
  logic [2:0]  err_count;
  logic [7:0]  fail_index;
  logic [31:0] fail_expected, fail_actual;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axil_regcheck_master_if #(.ADDR_W(32), .DATA_W(32)) m_axi ();

  axil_regcheck_master #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NREG),
    .BASE_ADDR(32'h0), .TIMEOUT(TOUT)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .resp_err(resp_err), .timeout(timeout), .fail_index(fail_index),
    .fail_expected(fail_expected), .fail_actual(fail_actual), .m_axi(m_axi)
  );

  // Slave configuration, written only by the stimulus process.
  int          aw_pct = 100, w_pct = 100, ar_pct = 100, w_delay = 0;
  int          bad_b = -1, bad_r = -1;
  logic        aw_block = 1'b0;
  logic [31:0] bad_val = '0;

  logic        aw_rdy_q, w_rdy_q, ar_rdy_q, got_aw, got_w, aw_seen, s_bvalid, s_rvalid;
  logic [31:0] aw_addr_s, w_data_s, s_rdata;
  logic [1:0]  s_bresp;
  int          aw_age;
  logic [31:0] mem [256];
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] wr_a, wr_d;

  assign aw_hs = m_axi.AWVALID && m_axi.AWREADY;
  assign w_hs  = m_axi.WVALID && m_axi.WREADY;
  assign ar_hs = m_axi.ARVALID && m_axi.ARREADY;
  assign wr_a  = got_aw ? aw_addr_s : m_axi.AWADDR;
  assign wr_d  = got_w ? w_data_s : m_axi.WDATA;

  assign m_axi.AWREADY = !aw_block && aw_rdy_q;
  assign m_axi.WREADY  = (w_delay > 0) ? (aw_seen && aw_age >= w_delay) : w_rdy_q;
  assign m_axi.ARREADY = ar_rdy_q;
  assign m_axi.BVALID  = s_bvalid;
  assign m_axi.BRESP   = s_bresp;
  assign m_axi.RVALID  = s_rvalid;
  assign m_axi.RDATA   = s_rdata;
  assign m_axi.RRESP   = 2'b00;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      got_aw <= 1'b0; got_w <= 1'b0; aw_seen <= 1'b0; aw_age <= 0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rdata <= '0;
      aw_addr_s <= '0; w_data_s <= '0;
      aw_rdy_q <= 1'b1; w_rdy_q <= 1'b1; ar_rdy_q <= 1'b1;
    end else begin
      aw_rdy_q <= int'($urandom_range(0, 99)) < aw_pct;
      w_rdy_q  <= int'($urandom_range(0, 99)) < w_pct;
      ar_rdy_q <= int'($urandom_range(0, 99)) < ar_pct;
      if (s_bvalid && m_axi.BREADY) s_bvalid <= 1'b0;
      if (s_rvalid && m_axi.RREADY) s_rvalid <= 1'b0;
      if (aw_hs) begin
        got_aw <= 1'b1; aw_addr_s <= m_axi.AWADDR; aw_seen <= 1'b1; aw_age <= 1;
      end else if (aw_seen) aw_age <= aw_age + 1;
      if (w_hs) begin got_w <= 1'b1; w_data_s <= m_axi.WDATA; end
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        mem[wr_a[9:2]] <= wr_d;
        s_bvalid <= 1'b1;
        s_bresp  <= (int'(wr_a[9:2]) == bad_b) ? 2'b10 : 2'b00;
        got_aw <= 1'b0; got_w <= 1'b0; aw_seen <= 1'b0;
      end
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (int'(m_axi.ARADDR[9:2]) == bad_r) ? bad_val : mem[m_axi.ARADDR[9:2]];
      end
    end
  end

  // Transaction log; tests index it from a snapshot of its size.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          ar_cnt = 0;
  always @(posedge ACLK) begin
    if (ARESETN) begin
      if (aw_hs) wr_addr_q.push_back(m_axi.AWADDR);
      if (w_hs)  wr_data_q.push_back(m_axi.WDATA);
      if (ar_hs) ar_cnt <= ar_cnt + 1;
    end
  end

  function automatic logic [31:0] pat(input logic m, input logic [31:0] s, input int i);
    int k;
    k = i % 32;
    if (m) return 32'h1 << k;
    if (k == 0) return s;
    return (s << k) | (s >> (32 - k));
  endfunction

  task automatic model(input logic m, input logic [31:0] s, input int bb, input int br,
                       input logic [31:0] bv, output int e_err, output logic e_resp,
                       output int e_idx, output logic [31:0] e_exp, output logic [31:0] e_act);
    logic f;
    e_err = 0; e_resp = (bb >= 0 && bb < NREG); e_idx = 0; e_exp = '0; e_act = '0;
    for (int i = 0; i < NREG; i++) begin
      f = (i == bb) || (i == br && bv != pat(m, s, i));
      if (f) begin
        if (e_err == 0) begin
          e_idx = i; e_exp = pat(m, s, i);
          e_act = (i == br) ? bv : pat(m, s, i);
        end
        e_err++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK); ARESETN = 1'b0; start = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1'b1;
  endtask

  task automatic run_sweep(input logic m, input logic [31:0] s, input int poke_at,
                           output int edges);
    @(negedge ACLK); mode = m; seed = s; start = 1'b1;
    @(posedge ACLK); #1; start = 1'b0;
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge ACLK); #1; edges++;
      if (edges == poke_at) begin
        start = 1'b1; seed = $urandom; mode = ~m;
      end else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if ({busy, done, pass, resp_err, timeout} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, done, pass, resp_err, timeout}); end
    total++; if (err_count !== 3'd0) begin bad++;
      $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    total++; if ({fail_index, fail_expected, fail_actual} !== '0) begin bad++;
      $display("FAIL reset_fail_capture got=%h exp=0", {fail_index, fail_expected, fail_actual}); end
    total++; if ({m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID, m_axi.RREADY} !== 5'b0) begin
      bad++; $display("FAIL reset_valids got=%b exp=00000",
        {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID, m_axi.RREADY}); end
    total++; if ({m_axi.WSTRB, m_axi.AWPROT, m_axi.ARPROT} !== {4'hF, 6'b0}) begin bad++;
      $display("FAIL strb_prot got=%h exp=%h", {m_axi.WSTRB, m_axi.AWPROT, m_axi.ARPROT}, {4'hF, 6'b0}); end
  endtask

  task automatic test_mode0_ideal();
    int edges, wa, wd, ac;
    logic [31:0] exp_tab [4] = '{32'h0101FFFF, 32'h0203FFFE, 32'h0407FFFC, 32'h080FFFF8};
    do_reset();
    wa = wr_addr_q.size(); wd = wr_data_q.size(); ac = ar_cnt;
    run_sweep(1'b0, 32'h0101FFFF, 0, edges);
    total++; if ({done, pass, busy} !== 3'b110) begin bad++;
      $display("FAIL m0_done_pass_busy got=%b exp=110", {done, pass, busy}); end
    total++; if (err_count !== 3'd0) begin bad++;
      $display("FAIL m0_err_count got=%0d exp=0", err_count); end
    total++; if (edges + 2 != 4 * NREG + 2) begin bad++;
      $display("FAIL m0_cycles got=%0d exp=%0d", edges + 2, 4 * NREG + 2); end
    total++; if (wr_data_q.size() - wd != NREG || ar_cnt - ac != NREG) begin bad++;
      $display("FAIL m0_txn_count got=%0d/%0d exp=%0d", wr_data_q.size() - wd, ar_cnt - ac, NREG); end
    for (int i = 0; i < NREG; i++) begin
      total++; if (wr_addr_q[wa + i] !== 32'(i * 4)) begin bad++;
        $display("FAIL m0_addr[%0d] got=%h exp=%h", i, wr_addr_q[wa + i], 32'(i * 4)); end
      total++; if (wr_data_q[wd + i] !== exp_tab[i]) begin bad++;
        $display("FAIL m0_data[%0d] got=%h exp=%h", i, wr_data_q[wd + i], exp_tab[i]); end
    end
  endtask

  task automatic test_mode1();
    int edges, wd;
    logic [31:0] s;
    s = $urandom;
    do_reset();
    wd = wr_data_q.size();
    run_sweep(1'b1, s, 0, edges);
    for (int i = 0; i < NREG; i++) begin
      total++; if (wr_data_q[wd + i] !== pat(1'b1, s, i)) begin bad++;
        $display("FAIL m1_data[%0d] got=%h exp=%h", i, wr_data_q[wd + i], pat(1'b1, s, i)); end
    end
    total++; if ({done, pass, err_count} !== {2'b11, 3'd0}) begin bad++;
      $display("FAIL m1_result got=%b exp=11000", {done, pass, err_count}); end
  endtask

  task automatic test_bad_read();
    int edges;
    do_reset();
    bad_r = 2; bad_val = 32'hDEAD0011;
    run_sweep(1'b0, 32'h0101FFFF, 0, edges);
    bad_r = -1;
    total++; if ({done, pass, resp_err, timeout} !== 4'b1000) begin bad++;
      $display("FAIL badrd_flags got=%b exp=1000", {done, pass, resp_err, timeout}); end
    total++; if (err_count !== 3'd1 || fail_index !== 8'd2) begin bad++;
      $display("FAIL badrd_count_idx got=%0d/%0d exp=1/2", err_count, fail_index); end
    total++; if (fail_expected !== 32'h0407FFFC || fail_actual !== 32'hDEAD0011) begin bad++;
      $display("FAIL badrd_capture got=%h/%h exp=0407fffc/dead0011", fail_expected, fail_actual); end
  endtask

  task automatic test_bad_bresp();
    int edges, ac;
    do_reset();
    bad_b = 1; ac = ar_cnt;
    run_sweep(1'b0, 32'h0101FFFF, 0, edges);
    bad_b = -1;
    total++; if ({done, pass, resp_err} !== 3'b101) begin bad++;
      $display("FAIL bresp_flags got=%b exp=101", {done, pass, resp_err}); end
    total++; if (err_count !== 3'd1 || fail_index !== 8'd1) begin bad++;
      $display("FAIL bresp_count_idx got=%0d/%0d exp=1/1", err_count, fail_index); end
    total++; if (ar_cnt - ac != NREG) begin bad++;
      $display("FAIL bresp_reads got=%0d exp=%0d", ar_cnt - ac, NREG); end
    total++; if (fail_expected !== 32'h0203FFFE || fail_actual !== 32'h0203FFFE) begin bad++;
      $display("FAIL bresp_capture got=%h/%h exp=0203fffe", fail_expected, fail_actual); end
  endtask

  task automatic test_timeout();
    int edges;
    do_reset();
    aw_block = 1'b1;
    run_sweep(1'b0, $urandom, 0, edges);
    total++; if ({done, timeout, pass, busy} !== 4'b1100) begin bad++;
      $display("FAIL to_flags got=%b exp=1100", {done, timeout, pass, busy}); end
    total++; if (edges > 17) begin bad++;
      $display("FAIL to_latency got=%0d exp<=17", edges); end
    total++; if ({m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID, m_axi.RREADY} !== 5'b0) begin
      bad++; $display("FAIL to_valids got=%b exp=00000",
        {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID, m_axi.RREADY}); end
    aw_block = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    int n, wd, wa, edges;
    logic [31:0] s;
    s = $urandom;
    do_reset();
    w_delay = 3;
    wd = wr_data_q.size(); wa = wr_addr_q.size();
    @(negedge ACLK); mode = 1'b0; seed = s; start = 1'b1;
    @(posedge ACLK); #1; start = 1'b0;
    n = 0;
    while (!m_axi.ARVALID && n < 40) begin @(posedge ACLK); #1; n++; end
    total++; if (m_axi.ARVALID !== 1'b1) begin bad++;
      $display("FAIL mid_reach_ra got=%b exp=1", m_axi.ARVALID); end
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    total++; if ({busy, done, pass, resp_err, timeout, err_count} !== 8'b0) begin bad++;
      $display("FAIL mid_reset_status got=%b exp=0", {busy, done, pass, resp_err, timeout, err_count}); end
    total++; if ({fail_index, fail_expected, fail_actual} !== '0 ||
                 {m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID, m_axi.RREADY} !== 5'b0) begin
      bad++; $display("FAIL mid_reset_outputs got=%h exp=0",
        {fail_index, m_axi.AWVALID, m_axi.WVALID, m_axi.BREADY, m_axi.ARVALID, m_axi.RREADY}); end
    total++; if (wr_data_q.size() - wd != 1 || wr_data_q[wd] !== pat(1'b0, s, 0) || wr_addr_q[wa] !== 32'h0)
    begin bad++;
      $display("FAIL mid_write got=%h@%h exp=%h@0", wr_data_q[wd], wr_addr_q[wa], pat(1'b0, s, 0)); end
    @(negedge ACLK); ARESETN = 1'b1;
    run_sweep(1'b0, $urandom, 0, edges);
    total++; if ({done, pass, err_count} !== {2'b11, 3'd0}) begin bad++;
      $display("FAIL mid_rerun got=%b exp=11000", {done, pass, err_count}); end
    w_delay = 0;
  endtask

  task automatic test_random();
    int edges, wd, ac, e_err, e_idx;
    logic m, e_resp;
    logic [31:0] s, e_exp, e_act;
    for (int it = 0; it < 20; it++) begin
      do_reset();
      aw_pct = $urandom_range(60, 100); w_pct = $urandom_range(60, 100);
      ar_pct = $urandom_range(60, 100);
      bad_b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NREG - 1) : -1;
      bad_r = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NREG - 1) : -1;
      bad_val = $urandom;
      m = 1'($urandom_range(0, 1)); s = $urandom;
      model(m, s, bad_b, bad_r, bad_val, e_err, e_resp, e_idx, e_exp, e_act);
      wd = wr_data_q.size(); ac = ar_cnt;
      run_sweep(m, s, 3, edges);
      total++; if ({done, timeout, pass} !== {2'b10, e_err == 0}) begin bad++;
        $display("FAIL rnd%0d_flags got=%b exp=%b", it, {done, timeout, pass}, {2'b10, e_err == 0}); end
      total++; if (err_count !== 3'(e_err) || resp_err !== e_resp) begin bad++;
        $display("FAIL rnd%0d_err got=%0d/%b exp=%0d/%b", it, err_count, resp_err, e_err, e_resp); end
      total++; if (fail_index !== 8'(e_idx) || fail_expected !== e_exp || fail_actual !== e_act) begin
        bad++; $display("FAIL rnd%0d_capture got=%0d/%h/%h exp=%0d/%h/%h", it, fail_index,
          fail_expected, fail_actual, e_idx, e_exp, e_act); end
      total++; if (ar_cnt - ac != NREG) begin bad++;
        $display("FAIL rnd%0d_reads got=%0d exp=%0d", it, ar_cnt - ac, NREG); end
      for (int i = 0; i < NREG; i++) begin
        total++; if (wr_data_q[wd + i] !== pat(m, s, i)) begin bad++;
          $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", it, i, wr_data_q[wd + i], pat(m, s, i)); end
      end
    end
    aw_pct = 100; w_pct = 100; ar_pct = 100; bad_b = -1; bad_r = -1;
  endtask

  initial begin
    test_reset();
    test_mode0_ideal();
    test_mode1();
    test_bad_read();
    test_bad_bresp();
    test_timeout();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
